// File: rtl/xbar_master_interface.sv
// Crossbar port facing one outer AXI slave: round-robin AR/AW arbitration across master-side
// ports, W locked to the AW winner, pending FIFOs on every channel, R/B tagged by destination.

module xbar_mi_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    // Push only against the fullness seen at the start of the cycle, even if a pop coincides.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

module xbar_mi_rr_arb #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] rr;
    logic [IW-1:0] cand;
    logic          found;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    // Search starts at rr, so the last winner has lowest priority next time.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = wrap_add(rr, k);
            if (en && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= '0;
        end else if (found) begin
            rr <= wrap_add(idx, 1);
        end
    end
endmodule

module xbar_master_interface #(
    parameter int ID_WIDTH          = 4,
    parameter int IDS_WIDTH         = 8,
    parameter int ADDR_WIDTH        = 32,
    parameter int LEN_WIDTH         = 4,
    parameter int SIZE_WIDTH        = 3,
    parameter int DATA_WIDTH        = 32,
    parameter int STRB_WIDTH        = 4,
    parameter int pending_depth     = 8,
    parameter int masters           = 2,
    parameter int i_am_slave_number = 0,
    localparam int MIW  = (masters > 1) ? $clog2(masters) : 1,
    localparam int AX_W = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + SIZE_WIDTH + 2,
    localparam int W_W  = DATA_WIDTH + STRB_WIDTH + 1,
    localparam int R_W  = ID_WIDTH + DATA_WIDTH + 3,
    localparam int B_W  = ID_WIDTH + 2
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [masters-1:0]      ar_req,
    input  logic [masters*AX_W-1:0] ar_pld,
    output logic [masters-1:0]      ar_grant,
    input  logic [masters-1:0]      aw_req,
    input  logic [masters*AX_W-1:0] aw_pld,
    output logic [masters-1:0]      aw_grant,
    input  logic [masters-1:0]      w_req,
    input  logic [masters*W_W-1:0]  w_pld,
    output logic [masters-1:0]      w_grant,
    output logic                    w_lock,
    output logic                    r_empty,
    output logic [MIW-1:0]          r_dest_master,
    output logic [R_W-1:0]          r_pld,
    input  logic                    r_pop,
    output logic                    b_empty,
    output logic [MIW-1:0]          b_dest_master,
    output logic [B_W-1:0]          b_pld,
    input  logic                    b_pop,
    output logic [IDS_WIDTH-1:0]    ARID_S,
    output logic [ADDR_WIDTH-1:0]   ARADDR_S,
    output logic [LEN_WIDTH-1:0]    ARLEN_S,
    output logic [SIZE_WIDTH-1:0]   ARSIZE_S,
    output logic [1:0]              ARBURST_S,
    output logic                    ARVALID_S,
    input  logic                    ARREADY_S,
    input  logic [IDS_WIDTH-1:0]    RID_S,
    input  logic [DATA_WIDTH-1:0]   RDATA_S,
    input  logic [1:0]              RRESP_S,
    input  logic                    RLAST_S,
    input  logic                    RVALID_S,
    output logic                    RREADY_S,
    output logic [IDS_WIDTH-1:0]    AWID_S,
    output logic [ADDR_WIDTH-1:0]   AWADDR_S,
    output logic [LEN_WIDTH-1:0]    AWLEN_S,
    output logic [SIZE_WIDTH-1:0]   AWSIZE_S,
    output logic [1:0]              AWBURST_S,
    output logic                    AWVALID_S,
    input  logic                    AWREADY_S,
    output logic [DATA_WIDTH-1:0]   WDATA_S,
    output logic [STRB_WIDTH-1:0]   WSTRB_S,
    output logic                    WLAST_S,
    output logic                    WVALID_S,
    input  logic                    WREADY_S,
    input  logic [IDS_WIDTH-1:0]    BID_S,
    input  logic [1:0]              BRESP_S,
    input  logic                    BVALID_S,
    output logic                    BREADY_S
);
    // Handshake rule on every channel: a transfer happens in a cycle where valid (req / VALID /
    // !empty) and ready (grant / READY / pop) are both high; a held payload never changes.
    localparam int AXS_W = IDS_WIDTH + AX_W - ID_WIDTH;
    localparam int RQ_W  = MIW + R_W;
    localparam int BQ_W  = MIW + B_W;

    if (i_am_slave_number < 0 || IDS_WIDTH < ID_WIDTH + MIW) begin : g_cfg_check
        $error("xbar_master_interface: bad slave number or IDS_WIDTH too narrow");
    end

    typedef enum logic {W_IDLE, W_LOCKED} w_state_t;

    logic [MIW-1:0]   ar_idx;
    logic [MIW-1:0]   aw_idx;
    logic             aw_any;
    logic             ar_full, ar_empty, aw_full, aw_empty, w_full, w_empty;
    logic             r_full, b_full;
    logic [AXS_W-1:0] ar_din, ar_dout, aw_din, aw_dout;
    logic [W_W-1:0]   w_beat, w_dout;
    logic [RQ_W-1:0]  r_din, r_dout;
    logic [BQ_W-1:0]  b_din, b_dout;
    logic             r_keep, b_keep;
    w_state_t         w_state, w_state_next;
    logic [MIW-1:0]   w_owner;
    logic             w_push;

    // Slave-side ID = {zero-extended master index, master ID}.
    function automatic logic [AXS_W-1:0] widen_ax(input logic [AX_W-1:0] pld, input logic [MIW-1:0] m);
        logic [IDS_WIDTH-1:0] ids;
        ids                  = '0;
        ids[ID_WIDTH +: MIW] = m;
        ids[ID_WIDTH-1:0]    = pld[AX_W-1 -: ID_WIDTH];
        return {ids, pld[AX_W-ID_WIDTH-1:0]};
    endfunction

    xbar_mi_rr_arb #(.N(masters), .IW(MIW)) u_ar_arb (
        .clk(ACLK), .rst(ARESET), .req(ar_req), .en(!ar_full), .grant(ar_grant), .idx(ar_idx)
    );

    xbar_mi_rr_arb #(.N(masters), .IW(MIW)) u_aw_arb (
        .clk(ACLK), .rst(ARESET), .req(aw_req), .en(!aw_full && !w_lock), .grant(aw_grant), .idx(aw_idx)
    );

    assign ar_din = widen_ax(ar_pld[int'(ar_idx)*AX_W +: AX_W], ar_idx);
    assign aw_din = widen_ax(aw_pld[int'(aw_idx)*AX_W +: AX_W], aw_idx);
    assign aw_any = |aw_grant;

    xbar_mi_fifo #(.WIDTH(AXS_W), .DEPTH(pending_depth)) u_ar_fifo (
        .clk(ACLK), .rst(ARESET), .push(|ar_grant), .din(ar_din), .pop(ARVALID_S && ARREADY_S),
        .dout(ar_dout), .empty(ar_empty), .full(ar_full)
    );

    assign ARVALID_S = !ar_empty;
    assign {ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S} = ar_dout;

    xbar_mi_fifo #(.WIDTH(AXS_W), .DEPTH(pending_depth)) u_aw_fifo (
        .clk(ACLK), .rst(ARESET), .push(aw_any), .din(aw_din), .pop(AWVALID_S && AWREADY_S),
        .dout(aw_dout), .empty(aw_empty), .full(aw_full)
    );

    assign AWVALID_S = !aw_empty;
    assign {AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S} = aw_dout;

    // W ownership: an AW grant locks W to its master until that master's WLAST beat is taken,
    // which keeps W order at the slave identical to AW order.
    assign w_beat = w_pld[int'(w_owner)*W_W +: W_W];
    assign w_lock = (w_state == W_LOCKED);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state <= W_IDLE;
            w_owner <= '0;
        end else begin
            w_state <= w_state_next;
            if (aw_any) w_owner <= aw_idx;
        end
    end

    always_comb begin
        w_state_next = w_state;
        w_push       = 1'b0;
        w_grant      = '0;
        case (w_state)
            W_IDLE: begin
                if (aw_any) w_state_next = W_LOCKED;
            end
            W_LOCKED: begin
                w_push           = w_req[w_owner] && !w_full;
                w_grant[w_owner] = w_push;
                if (w_push && w_beat[0]) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    xbar_mi_fifo #(.WIDTH(W_W), .DEPTH(pending_depth)) u_w_fifo (
        .clk(ACLK), .rst(ARESET), .push(w_push), .din(w_beat), .pop(WVALID_S && WREADY_S),
        .dout(w_dout), .empty(w_empty), .full(w_full)
    );

    assign WVALID_S = !w_empty;
    assign {WDATA_S, WSTRB_S, WLAST_S} = w_dout;

    // Returns whose master prefix names no real port are absorbed but never queued.
    assign r_keep   = int'(RID_S[IDS_WIDTH-1:ID_WIDTH]) < masters;
    assign RREADY_S = !r_full;
    assign r_din    = {RID_S[ID_WIDTH +: MIW], RID_S[ID_WIDTH-1:0], RDATA_S, RRESP_S, RLAST_S};

    xbar_mi_fifo #(.WIDTH(RQ_W), .DEPTH(pending_depth)) u_r_fifo (
        .clk(ACLK), .rst(ARESET), .push(RVALID_S && RREADY_S && r_keep), .din(r_din), .pop(r_pop),
        .dout(r_dout), .empty(r_empty), .full(r_full)
    );

    assign {r_dest_master, r_pld} = r_dout;

    assign b_keep   = int'(BID_S[IDS_WIDTH-1:ID_WIDTH]) < masters;
    assign BREADY_S = !b_full;
    assign b_din    = {BID_S[ID_WIDTH +: MIW], BID_S[ID_WIDTH-1:0], BRESP_S};

    xbar_mi_fifo #(.WIDTH(BQ_W), .DEPTH(pending_depth)) u_b_fifo (
        .clk(ACLK), .rst(ARESET), .push(BVALID_S && BREADY_S && b_keep), .din(b_din), .pop(b_pop),
        .dout(b_dout), .empty(b_empty), .full(b_full)
    );

    assign {b_dest_master, b_pld} = b_dout;
endmodule

// File: tb/tb_xbar_master_interface.sv
// Bench for xbar_master_interface: directed scenarios plus random traffic, all checked
// against a queue-based model of the port built from the channel rules.

module tb_xbar_master_interface;
    localparam int M     = 2;
    localparam int IDW   = 4;
    localparam int IDSW  = 8;
    localparam int ADW   = 32;
    localparam int LW    = 4;
    localparam int SW    = 3;
    localparam int DW    = 32;
    localparam int SBW   = 4;
    localparam int DEPTH = 8;
    localparam int AR_W  = IDW + ADW + LW + SW + 2;
    localparam int AR_E  = IDSW + ADW + LW + SW + 2;
    localparam int W_W   = DW + SBW + 1;
    localparam int R_W   = IDW + DW + 3;
    localparam int B_W   = IDW + 2;

    logic              ACLK, ARESET;
    logic [M-1:0]      ar_req, ar_grant, aw_req, aw_grant, w_req, w_grant;
    logic [M*AR_W-1:0] ar_pld, aw_pld;
    logic [M*W_W-1:0]  w_pld;
    logic              w_lock;
    logic              r_empty, r_pop, b_empty, b_pop;
    logic [0:0]        r_dest_master, b_dest_master;
    logic [R_W-1:0]    r_pld;
    logic [B_W-1:0]    b_pld;
    logic [IDSW-1:0]   ARID_S, AWID_S, RID_S, BID_S;
    logic [ADW-1:0]    ARADDR_S, AWADDR_S;
    logic [LW-1:0]     ARLEN_S, AWLEN_S;
    logic [SW-1:0]     ARSIZE_S, AWSIZE_S;
    logic [1:0]        ARBURST_S, AWBURST_S, RRESP_S, BRESP_S;
    logic              ARVALID_S, ARREADY_S, AWVALID_S, AWREADY_S;
    logic [DW-1:0]     RDATA_S, WDATA_S;
    logic [SBW-1:0]    WSTRB_S;
    logic              RLAST_S, RVALID_S, RREADY_S, WLAST_S, WVALID_S, WREADY_S;
    logic              BVALID_S, BREADY_S;

    xbar_master_interface #(
        .ID_WIDTH(IDW), .IDS_WIDTH(IDSW), .ADDR_WIDTH(ADW), .LEN_WIDTH(LW), .SIZE_WIDTH(SW),
        .DATA_WIDTH(DW), .STRB_WIDTH(SBW), .pending_depth(DEPTH), .masters(M), .i_am_slave_number(0)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .ar_req(ar_req), .ar_pld(ar_pld), .ar_grant(ar_grant),
        .aw_req(aw_req), .aw_pld(aw_pld), .aw_grant(aw_grant),
        .w_req(w_req), .w_pld(w_pld), .w_grant(w_grant), .w_lock(w_lock),
        .r_empty(r_empty), .r_dest_master(r_dest_master), .r_pld(r_pld), .r_pop(r_pop),
        .b_empty(b_empty), .b_dest_master(b_dest_master), .b_pld(b_pld), .b_pop(b_pop),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
        .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
        .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
        .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
        .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
        .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S),
        .WREADY_S(WREADY_S),
        .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S), .BREADY_S(BREADY_S)
    );

    // ---------------- clock / reset ----------------
    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;

    logic [AR_E-1:0]  arq[$];
    logic [AR_E-1:0]  awq[$];
    logic [W_W-1:0]   wq[$];
    logic [R_W:0]     rq[$];
    logic [B_W:0]     bq[$];
    int               rr_ar, rr_aw, owner;
    bit               lock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        arq.delete(); awq.delete(); wq.delete(); rq.delete(); bq.delete();
        rr_ar = 0; rr_aw = 0; owner = 0; lock = 1'b0;
    endtask

    function automatic int pick(input int rr, input logic [M-1:0] req);
        for (int k = 0; k < M; k++) if (req[(rr + k) % M]) return (rr + k) % M;
        return -1;
    endfunction

    function automatic logic [AR_E-1:0] widen(input int m, input logic [AR_W-1:0] p);
        logic [IDSW-1:0] ids;
        ids = IDSW'(m * (1 << IDW)) + IDSW'(p[AR_W-1 -: IDW]);
        return {ids, p[AR_W-IDW-1:0]};
    endfunction

    // Checks the settled outputs of the current cycle, then advances the model by one clock.
    task automatic step();
        int           a, w;
        logic [M-1:0] ea, ew, eg;
        bit           wpush, ar_pop, aw_pop, w_pop, r_popm, b_popm, r_free, b_free;
        #1;
        a  = (arq.size() < DEPTH) ? pick(rr_ar, ar_req) : -1;
        w  = (awq.size() < DEPTH && !lock) ? pick(rr_aw, aw_req) : -1;
        ea = '0; if (a >= 0) ea[a] = 1'b1;
        ew = '0; if (w >= 0) ew[w] = 1'b1;
        wpush = lock && w_req[owner] && wq.size() < DEPTH;
        eg = '0; if (wpush) eg[owner] = 1'b1;

        check_eq("ar_grant", 64'(ar_grant), 64'(ea));
        check_eq("ar_valid", 64'(ARVALID_S), 64'(arq.size() != 0));
        if (arq.size() != 0)
            check_eq("ar_front", 64'({ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S}), 64'(arq[0]));
        check_eq("aw_grant", 64'(aw_grant), 64'(ew));
        check_eq("aw_valid", 64'(AWVALID_S), 64'(awq.size() != 0));
        if (awq.size() != 0)
            check_eq("aw_front", 64'({AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S}), 64'(awq[0]));
        check_eq("w_grant", 64'(w_grant), 64'(eg));
        check_eq("w_lock", 64'(w_lock), 64'(lock));
        check_eq("w_valid", 64'(WVALID_S), 64'(wq.size() != 0));
        if (wq.size() != 0) check_eq("w_front", 64'({WDATA_S, WSTRB_S, WLAST_S}), 64'(wq[0]));
        check_eq("r_ready", 64'(RREADY_S), 64'(rq.size() < DEPTH));
        check_eq("r_empty", 64'(r_empty), 64'(rq.size() == 0));
        if (rq.size() != 0) check_eq("r_front", 64'({r_dest_master, r_pld}), 64'(rq[0]));
        check_eq("b_ready", 64'(BREADY_S), 64'(bq.size() < DEPTH));
        check_eq("b_empty", 64'(b_empty), 64'(bq.size() == 0));
        if (bq.size() != 0) check_eq("b_front", 64'({b_dest_master, b_pld}), 64'(bq[0]));

        if (ARESET) begin
            model_reset();
        end else begin
            ar_pop = arq.size() != 0 && ARREADY_S;
            aw_pop = awq.size() != 0 && AWREADY_S;
            w_pop  = wq.size() != 0 && WREADY_S;
            r_popm = r_pop && rq.size() != 0;
            b_popm = b_pop && bq.size() != 0;
            r_free = rq.size() < DEPTH;
            b_free = bq.size() < DEPTH;
            if (ar_pop) void'(arq.pop_front());
            if (aw_pop) void'(awq.pop_front());
            if (w_pop)  void'(wq.pop_front());
            if (r_popm) void'(rq.pop_front());
            if (b_popm) void'(bq.pop_front());
            if (a >= 0) begin
                arq.push_back(widen(a, ar_pld[a*AR_W +: AR_W]));
                rr_ar = (a + 1) % M;
            end
            if (wpush) begin
                wq.push_back(w_pld[owner*W_W +: W_W]);
                if (w_pld[owner*W_W]) lock = 1'b0;
            end
            if (w >= 0) begin
                awq.push_back(widen(w, aw_pld[w*AR_W +: AR_W]));
                rr_aw = (w + 1) % M;
                lock  = 1'b1;
                owner = w;
            end
            if (RVALID_S && r_free && (RID_S >> IDW) < M)
                rq.push_back({RID_S[IDW], RID_S[IDW-1:0], RDATA_S, RRESP_S, RLAST_S});
            if (BVALID_S && b_free && (BID_S >> IDW) < M)
                bq.push_back({BID_S[IDW], BID_S[IDW-1:0], BRESP_S});
        end
        @(posedge ACLK);
        @(negedge ACLK);
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        ARESET = 1'b0;
        ar_req = '0; ar_pld = '0; aw_req = '0; aw_pld = '0; w_req = '0; w_pld = '0;
        ARREADY_S = 1'b1; AWREADY_S = 1'b1; WREADY_S = 1'b1;
        RVALID_S = 1'b0; RID_S = '0; RDATA_S = '0; RRESP_S = '0; RLAST_S = 1'b0;
        BVALID_S = 1'b0; BID_S = '0; BRESP_S = '0;
        r_pop = 1'b0; b_pop = 1'b0;
    endtask

    function automatic logic [3:0] rid_hi();
        int r;
        r = $urandom_range(0, 9);
        return (r < 8) ? 4'(r % 2) : 4'($urandom_range(2, 15));
    endfunction

    task automatic rand_inputs();
        ARESET = ($urandom_range(0, 499) == 0);
        ar_req = M'($urandom_range(0, 3));
        aw_req = M'($urandom_range(0, 3));
        w_req  = M'($urandom_range(0, 3));
        for (int i = 0; i < M; i++) begin
            ar_pld[i*AR_W +: AR_W] = AR_W'({$urandom, $urandom});
            aw_pld[i*AR_W +: AR_W] = AR_W'({$urandom, $urandom});
            w_pld[i*W_W +: W_W]    = {DW'($urandom), SBW'($urandom), ($urandom_range(0, 3) == 0)};
        end
        ARREADY_S = ($urandom_range(0, 99) < 70);
        AWREADY_S = ($urandom_range(0, 99) < 70);
        WREADY_S  = ($urandom_range(0, 99) < 70);
        RVALID_S  = ($urandom_range(0, 1) == 1);
        RID_S     = {rid_hi(), 4'($urandom)};
        RDATA_S   = $urandom;
        RRESP_S   = 2'($urandom);
        RLAST_S   = 1'($urandom);
        BVALID_S  = ($urandom_range(0, 1) == 1);
        BID_S     = {rid_hi(), 4'($urandom)};
        BRESP_S   = 2'($urandom);
        r_pop     = ($urandom_range(0, 99) < 60);
        b_pop     = ($urandom_range(0, 99) < 60);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        ARESET = 1'b1;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;
        model_reset();
        #1;
        check_eq("rst_ar_valid", 64'(ARVALID_S), 64'(0));
        check_eq("rst_aw_valid", 64'(AWVALID_S), 64'(0));
        check_eq("rst_w_valid", 64'(WVALID_S), 64'(0));
        check_eq("rst_r_ready", 64'(RREADY_S), 64'(1));
        check_eq("rst_b_ready", 64'(BREADY_S), 64'(1));
        check_eq("rst_r_empty", 64'(r_empty), 64'(1));
        check_eq("rst_b_empty", 64'(b_empty), 64'(1));
        check_eq("rst_w_lock", 64'(w_lock), 64'(0));
        step();

        // AR round robin with both masters requesting
        for (int k = 0; k < 4; k++) begin
            idle_inputs();
            ar_req = 2'b11;
            ar_pld[0 +: AR_W]    = {4'h3, 41'(k)};
            ar_pld[AR_W +: AR_W] = {4'h5, 41'(k + 100)};
            #1;
            check_eq("rr_ar_grant", 64'(ar_grant), 64'((k % 2 == 0) ? 1 : 2));
            if (k >= 1) check_eq("rr_arid", 64'(ARID_S), 64'((k % 2 == 1) ? 8'h03 : 8'h15));
            step();
        end
        idle_inputs();
        repeat (3) step();

        // AW to m1 locks W to m1 for a 4-beat burst; m0's AW waits
        idle_inputs();
        aw_req = 2'b10;
        aw_pld[AR_W +: AR_W] = {4'h7, 32'h1000, 4'd3, 3'd2, 2'd1};
        #1;
        check_eq("aw_first", 64'(aw_grant), 64'(2'b10));
        step();
        for (int b = 0; b < 4; b++) begin
            idle_inputs();
            aw_req = 2'b11;
            aw_pld[0 +: AR_W]    = {4'h2, 32'h2000, 4'd3, 3'd2, 2'd1};
            aw_pld[AR_W +: AR_W] = {4'h7, 32'h3000, 4'd0, 3'd2, 2'd1};
            w_req = 2'b11;
            w_pld[0 +: W_W]   = {32'hdead, 4'h1, 1'b1};
            w_pld[W_W +: W_W] = {32'(b), 4'hf, (b == 3)};
            #1;
            check_eq("w_owner_grant", 64'(w_grant), 64'(2'b10));
            check_eq("aw_blocked", 64'(aw_grant), 64'(0));
            step();
        end
        idle_inputs();
        aw_req = 2'b11;
        aw_pld[0 +: AR_W] = {4'h2, 32'h2000, 4'd3, 3'd2, 2'd1};
        #1;
        check_eq("aw_after_wlast", 64'(aw_grant), 64'(2'b01));
        step();

        // AR FIFO fill with the slave stalled, then one pop frees one slot
        for (int k = 0; k < 9; k++) begin
            idle_inputs();
            ARREADY_S = 1'b0;
            ar_req = 2'b01;
            ar_pld[0 +: AR_W] = {4'(k + 1), 41'(k * 7)};
            #1;
            check_eq("ar_fill_grant", 64'(ar_grant), 64'((k < 8) ? 1 : 0));
            if (k >= 1) check_eq("ar_stall_id", 64'(ARID_S), 64'(8'h01));
            step();
        end
        idle_inputs();
        ar_req = 2'b01;
        ar_pld[0 +: AR_W] = {4'h9, 41'(99)};
        #1;
        check_eq("ar_full_pop_grant", 64'(ar_grant), 64'(0));
        check_eq("ar_full_pop_id", 64'(ARID_S), 64'(8'h01));
        step();
        #1;
        check_eq("ar_refill_grant", 64'(ar_grant), 64'(1));
        check_eq("ar_next_id", 64'(ARID_S), 64'(8'h02));
        step();
        idle_inputs();
        repeat (10) step();

        // R tagging and out-of-range discard
        idle_inputs();
        RVALID_S = 1'b1; RID_S = 8'h1A; RDATA_S = 32'hcafe0001; RLAST_S = 1'b1;
        step();
        idle_inputs();
        #1;
        check_eq("r_tag_empty", 64'(r_empty), 64'(0));
        check_eq("r_tag_dest", 64'(r_dest_master), 64'(1));
        check_eq("r_tag_rid", 64'(r_pld[R_W-1 -: IDW]), 64'(4'hA));
        r_pop = 1'b1;
        step();
        idle_inputs();
        RVALID_S = 1'b1; RID_S = 8'h2A;
        step();
        idle_inputs();
        #1;
        check_eq("r_discard_empty", 64'(r_empty), 64'(1));
        step();

        // B FIFO full backpressure
        for (int k = 0; k < 8; k++) begin
            idle_inputs();
            BVALID_S = 1'b1; BID_S = {4'(k % 2), 4'(k)}; BRESP_S = 2'(k);
            step();
        end
        idle_inputs();
        BVALID_S = 1'b1; BID_S = 8'h03;
        #1;
        check_eq("b_full_ready", 64'(BREADY_S), 64'(0));
        check_eq("b_full_front", 64'({b_dest_master, b_pld}), 64'(0));
        b_pop = 1'b1; r_pop = 1'b1;
        step();
        idle_inputs();
        #1;
        check_eq("b_ready_after_pop", 64'(BREADY_S), 64'(1));
        step();

        // reset during beat 2 of m0's write burst (lock still held from the AW above)
        idle_inputs();
        WREADY_S = 1'b0; ARREADY_S = 1'b0; ar_req = 2'b01;
        w_req = 2'b01; w_pld[0 +: W_W] = {32'h11, 4'hf, 1'b0};
        #1;
        check_eq("burst_beat1", 64'(w_grant), 64'(2'b01));
        step();
        idle_inputs();
        WREADY_S = 1'b0; ARREADY_S = 1'b0;
        w_req = 2'b01; w_pld[0 +: W_W] = {32'h22, 4'hf, 1'b0};
        ARESET = 1'b1;
        step();
        idle_inputs();
        #1;
        check_eq("mid_rst_lock", 64'(w_lock), 64'(0));
        check_eq("mid_rst_ar_valid", 64'(ARVALID_S), 64'(0));
        check_eq("mid_rst_aw_valid", 64'(AWVALID_S), 64'(0));
        check_eq("mid_rst_w_valid", 64'(WVALID_S), 64'(0));
        check_eq("mid_rst_r_ready", 64'(RREADY_S), 64'(1));
        check_eq("mid_rst_b_ready", 64'(BREADY_S), 64'(1));
        check_eq("mid_rst_r_empty", 64'(r_empty), 64'(1));
        check_eq("mid_rst_b_empty", 64'(b_empty), 64'(1));
        step();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rand_inputs();
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
